// File: rtl/digital_word_unpacker.sv
// Receive-side word unpacker: requests a word from the packer, captures it on a
// synchronised dataReady edge and serialises it MSB-first over a valid/accept handshake.
module digital_word_unpacker #(
  parameter int WORD_W    = 12,
  parameter int RQ_LEN    = 4,
  parameter int TIMEOUT   = 255,
  parameter int DROP_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              dataRequest,
  input  logic [WORD_W-1:0] data,
  input  logic              dataReady,
  output logic              bitOut,
  output logic              bitValid,
  input  logic              bitAccept,
  output logic              wordZero,
  output logic [15:0]       zeroWords,
  output logic              timeoutErr
);

  localparam int RQ_W = $clog2(RQ_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int BC_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [2:0]          dr_sync;
  logic                dr_edge;
  logic [RQ_W-1:0]     rq_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic [WORD_W-1:0]   word;
  logic [WORD_W-1:0]   shreg;
  logic [15:0]         zero_cnt;
  logic                word_is_zero;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign dr_edge      = dr_sync[1] & ~dr_sync[2];
  assign word_is_zero = (word == '0);
  assign zeroWords    = zero_cnt;
  assign bitOut       = (state == SHIFT) ? shreg[WORD_W-1] : 1'b0;

  always_comb begin
    state_nxt   = state;
    dataRequest = 1'b0;
    bitValid    = 1'b0;
    wordZero    = 1'b0;
    timeoutErr  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = REQ;
      end
      REQ: begin
        dataRequest = 1'b1;
        // A fast producer may answer before the request window closes.
        if (dr_edge)                              state_nxt = CAPT;
        else if (rq_cnt == RQ_W'(RQ_LEN - 1))     state_nxt = WAIT;
      end
      WAIT: begin
        if (dr_edge) begin
          state_nxt = CAPT;
        end else if (to_cnt == TO_W'(TIMEOUT)) begin
          timeoutErr = 1'b1;
          state_nxt  = IDLE;
        end
      end
      CAPT: begin
        wordZero  = word_is_zero;
        state_nxt = (word_is_zero && (DROP_ZERO != 0)) ? IDLE : SHIFT;
      end
      SHIFT: begin
        bitValid = 1'b1;
        if (bitAccept && (bit_cnt == BC_W'(1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      dr_sync  <= 3'b000;
      rq_cnt   <= '0;
      to_cnt   <= '0;
      bit_cnt  <= '0;
      word     <= '0;
      shreg    <= '0;
      zero_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dr_sync <= {dr_sync[1:0], dataReady};
      case (state)
        IDLE: begin
          rq_cnt <= '0;
          to_cnt <= '0;
        end
        REQ: begin
          rq_cnt <= rq_cnt + RQ_W'(1);
          to_cnt <= to_cnt + TO_W'(1);
          if (dr_edge) word <= data;
        end
        WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (dr_edge) word <= data;
        end
        CAPT: begin
          if (word_is_zero) zero_cnt <= sat_inc(zero_cnt);
          if (!(word_is_zero && (DROP_ZERO != 0))) begin
            shreg   <= word;
            bit_cnt <= BC_W'(WORD_W);
          end
        end
        SHIFT: begin
          if (bitAccept) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - BC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
